// File: rtl/demux2_pkg.sv
// Shared types and defaults for the registered 1-to-2 demultiplexer.
package demux2_pkg;

    localparam int BIT_DEF   = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [BIT_DEF-1:0] data_t;

    typedef enum logic {
        DEST0 = 1'b0,
        DEST1 = 1'b1
    } dest_e;

endpackage

// File: rtl/demux2_if.sv
// Input stream, destination select and both output channels of demux2_reg.
interface demux2_if #(
    parameter int BIT   = demux2_pkg::BIT_DEF,
    parameter int CNT_W = demux2_pkg::CNT_W_DEF
);

    logic [BIT-1:0]   in;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic [BIT-1:0]   out0;
    logic             out0_valid;
    logic             out0_ready;
    logic [BIT-1:0]   out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // Producer of the input stream and consumer of both channels.
    modport master (
        output in, in_valid, sel, out0_ready, out1_ready,
        input  in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1
    );

    modport slave (
        input  in, in_valid, sel, out0_ready, out1_ready,
        output in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1
    );

endinterface

// File: rtl/demux2_slot.sv
// One-entry output holding slot with its valid flag and saturating transfer count.
module demux2_slot #(
    parameter int BIT   = demux2_pkg::BIT_DEF,
    parameter int CNT_W = demux2_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BIT-1:0]   load_data_i,
    input  logic             ready_i,
    output logic [BIT-1:0]   data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             can_load_o
);

    logic [BIT-1:0]   data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // A load wins over a drain, so a simultaneous drain and refill keeps valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign cnt_o      = cnt_q;
    assign can_load_o = !valid_q || ready_i;

endmodule

// File: rtl/demux2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes and per-channel counters.
// Define DEMUX2_RR_EN to ignore sel and alternate destinations with an internal pointer.
module demux2_reg
    import demux2_pkg::*;
#(
    parameter int BIT   = BIT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic      clk,
    input logic      rst_n,
    demux2_if.slave  bus
);

    dest_e dest;
    logic  can_load0;
    logic  can_load1;
    logic  in_ready;
    logic  accept;
    logic  load0;
    logic  load1;

`ifdef DEMUX2_RR_EN
    dest_e rr_q, rr_d;
    logic  unused_sel;

    assign unused_sel = bus.sel;

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (rr_q == DEST0) ? DEST1 : DEST0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= DEST0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign dest = rr_q;
`else
    assign dest = dest_e'(bus.sel);
`endif

    // in_ready depends only on the chosen slot and its consumer, never on in_valid.
    always_comb begin
        in_ready = (dest == DEST1) ? can_load1 : can_load0;
        accept   = bus.in_valid && in_ready;
        load0    = accept && (dest == DEST0);
        load1    = accept && (dest == DEST1);
    end

    assign bus.in_ready = in_ready;

    demux2_slot #(
        .BIT   (BIT),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load0),
        .load_data_i (bus.in),
        .ready_i     (bus.out0_ready),
        .data_o      (bus.out0),
        .valid_o     (bus.out0_valid),
        .cnt_o       (bus.cnt0),
        .can_load_o  (can_load0)
    );

    demux2_slot #(
        .BIT   (BIT),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load1),
        .load_data_i (bus.in),
        .ready_i     (bus.out1_ready),
        .data_o      (bus.out1),
        .valid_o     (bus.out1_valid),
        .cnt_o       (bus.cnt1),
        .can_load_o  (can_load1)
    );

endmodule

// File: doc/demux2_reg.md
Name: demux2_reg

Overview:
- Registered 1-to-2 demultiplexer; the return path for the mux2 datapath.
- Steers one BIT-wide input stream to one of two output channels using valid/ready handshakes.
- Each output channel owns a one-entry holding slot.
- Keeps a saturating transfer count per channel for lab bring-up and debug.

Parameters:
- BIT, 4: data width of the input and of both outputs.
- CNT_W, 8: width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  BIT  input data.
- in_valid  input  1  input data valid.
- in_ready  output  1  block can accept input this cycle.
- sel  input  1  destination select: 0 = out0, 1 = out1; sampled only on an accepted transfer.
- out0  output  BIT  channel 0 data.
- out0_valid  output  1  channel 0 slot full.
- out0_ready  input  1  channel 0 consumer ready.
- out1  output  BIT  channel 1 data.
- out1_valid  output  1  channel 1 slot full.
- out1_ready  input  1  channel 1 consumer ready.
- cnt0  output  CNT_W  accepted transfers routed to channel 0.
- cnt1  output  CNT_W  accepted transfers routed to channel 1.

Behaviour:
- Reset (async assert, sync release): out0, out1 = 0; out0_valid, out1_valid = 0; cnt0, cnt1 = 0; RR pointer = 0.
- Destination d is sel (or the RR pointer when DEMUX2_RR_EN is defined).
- in_ready = !outd_valid | outd_ready.
  - Combinational path from out*_ready to in_ready is intentional.
  - No path from in_valid to in_ready.
- Accept occurs when in_valid & in_ready.
  - Next edge: outd <= in, outd_valid <= 1, cntd += 1.
  - Latency is 1 cycle from accept to outd_valid.
- Drain: outX_valid & outX_ready with no refill that cycle → outX_valid <= 0; outX data holds its last value.
- Simultaneous drain and refill of the same slot → slot keeps valid = 1 and takes the new data; full throughput, one transfer per cycle.
- The non-selected channel is unaffected by input activity; it can drain in the same cycle the other channel fills.
- Data stability: while outX_valid = 1 and outX_ready = 0, outX holds stable.
- Backpressure: sel changes while the selected slot is full:
  - in_ready re-evaluates combinationally for the new destination.
  - No data is ever dropped or duplicated.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-transfer clears slots and counters immediately; any data in flight is discarded.

Optional Feature:
- Macro: DEMUX2_RR_EN.
- Defined:
  - sel is ignored; destination is an internal 1-bit pointer.
  - Pointer resets to 0 and toggles on every accepted transfer.
  - Stream is split alternately: out0, out1, out0, ...
  - in_ready tracks the slot at the pointer; a stalled channel stalls the whole input (strict alternation, no skipping).
- Undefined: destination = sel; no pointer register exists.

Decomposition:
- Package demux2_pkg:
  - BIT_DEF = 4, CNT_W_DEF = 8.
  - typedef logic [BIT_DEF-1:0] data_t.
  - enum dest_e {DEST0 = 0, DEST1 = 1}.
- Sub-module demux2_slot, instantiated twice:
  - Contains one data register, its valid flag and its saturating counter.
  - Inputs: load, load_data, ready.
  - Outputs: data, valid, cnt, can_load (= !valid | ready).
- The top level holds routing, in_ready selection and the optional RR pointer.

Test Plan:
1. Reset with rst_n = 0 mid-cycle, data pending → all outputs 0 immediately; cnt0 = cnt1 = 0.
2. Single route, both readys = 1: in = 4'h1, sel = 0, then in = 4'h3, sel = 1 → out0 = 4'h1 valid one cycle after accept, then out1 = 4'h3; cnt0 = 1, cnt1 = 1.
3. Backpressure: out0_ready = 0, send 4'h5 to channel 0, then 4'h6 to channel 0:
   - Second beat sees in_ready = 0 and out0 holds 4'h5.
   - Raise out0_ready → 4'h6 is loaded on the same edge 4'h5 drains; out0_valid stays 1.
4. Cross-channel independence: out0 stalled and full, send 4'hA with sel = 1 → accepted, out1 = 4'hA, out0 unchanged.
5. Saturation, CNT_W = 2: push 6 beats to channel 1 → cnt1 reaches 3 and holds; no wrap.
6. With DEMUX2_RR_EN: stream 4'h0..4'h5, sel held at 1 → out0 receives 0, 2, 4 and out1 receives 1, 3, 5. Stall out1 → in_ready drops after out0's next beat is accepted.
